// File: rtl/sca_rd_sched.sv
// SCA readout scheduler: queues L1A-matched blocks and sequences settle, convert and word shift per sample.
// Defining SCA_RD_SCHED_CNT_EN adds the EVT_CNT and DROP_CNT statistics outputs.
module sca_rd_sched #(
    parameter int NSAMP      = 8,
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 2,
    parameter int CONV_CYC   = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       L1A_MATCH,
    input  logic [6:0] L1A_BLK,
    input  logic       OUT_RDY,
    output logic [6:0] RADR,
    output logic [3:0] CHADR,
    output logic       ADC_CONV,
    output logic       WORD_STB,
    output logic       FIRST_WORD,
    output logic       LASTWORD,
    output logic       FREE_STB,
    output logic [6:0] FREE_BLK,
    output logic       DATAAVAIL,
    output logic       BUSY,
    output logic [4:0] QCNT,
    output logic       OVFL
`ifdef SCA_RD_SCHED_CNT_EN
    ,
    output logic [15:0] EVT_CNT,
    output logic [7:0]  DROP_CNT
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CONV, WAIT, SHIFT, NEXT, DONE} state_t;

    localparam int         AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] QFULL       = 5'(DEPTH);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [3:0] CONV_LAST   = 4'(CONV_CYC - 1);
    localparam logic [3:0] SAMP_LAST   = 4'(NSAMP - 1);

    state_t          state, state_d;
    logic [6:0]      fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            enq, deq, drop;
    logic [6:0]      base;
    logic [3:0]      samp;
    logic [3:0]      cyc_cnt;
    logic [7:0]      radr_sum;
    logic [6:0]      radr_wrap;

    // A full queue still accepts when the scheduler dequeues in the same cycle.
    assign deq  = (state == IDLE) && (QCNT != 5'd0);
    assign enq  = L1A_MATCH && ((QCNT != QFULL) || deq);
    assign drop = L1A_MATCH && !enq;

    // NOTE: the queue storage is not reset; the pointers and count alone define its contents.
    always_ff @(posedge CLK) begin
        if (enq) fifo_mem[wr_ptr] <= L1A_BLK;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            QCNT   <= '0;
            OVFL   <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   QCNT <= QCNT + 5'd1;
                2'b01:   QCNT <= QCNT - 5'd1;
                default: ;
            endcase
            if (drop) OVFL <= 1'b1;
        end
    end

    assign radr_sum  = {1'b0, base} + {4'b0, samp};
    assign radr_wrap = (radr_sum >= 8'd96) ? 7'(radr_sum - 8'd96) : radr_sum[6:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_d;
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state;
        ADC_CONV   = 1'b0;
        WORD_STB   = 1'b0;
        FIRST_WORD = 1'b0;
        LASTWORD   = 1'b0;
        FREE_STB   = 1'b0;
        FREE_BLK   = '0;
        case (state)
            IDLE:    if (QCNT != 5'd0) state_d = LOAD;
            LOAD:    state_d = SETTLE;
            SETTLE:  if (cyc_cnt == SETTLE_LAST) state_d = CONV;
            CONV: begin
                ADC_CONV = 1'b1;
                state_d  = WAIT;
            end
            WAIT:    if (cyc_cnt == CONV_LAST) state_d = SHIFT;
            SHIFT: begin
                WORD_STB   = OUT_RDY;
                FIRST_WORD = OUT_RDY && (samp == 4'd0) && (CHADR == 4'd0);
                if (OUT_RDY && (CHADR == 4'd15)) state_d = NEXT;
            end
            NEXT:    state_d = (samp == SAMP_LAST) ? DONE : LOAD;
            DONE: begin
                LASTWORD = 1'b1;
                FREE_STB = 1'b1;
                FREE_BLK = base;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            base    <= '0;
            samp    <= '0;
            cyc_cnt <= '0;
            RADR    <= '0;
            CHADR   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    CHADR <= '0;
                    if (deq) begin
                        base <= fifo_mem[rd_ptr];
                        samp <= '0;
                    end
                end
                LOAD: begin
                    RADR    <= radr_wrap;
                    cyc_cnt <= '0;
                end
                SETTLE:  cyc_cnt <= cyc_cnt + 4'd1;
                CONV:    cyc_cnt <= '0;
                WAIT: begin
                    CHADR   <= '0;
                    cyc_cnt <= cyc_cnt + 4'd1;
                end
                SHIFT:   if (OUT_RDY) CHADR <= CHADR + 4'd1;
                NEXT:    if (samp != SAMP_LAST) samp <= samp + 4'd1;
                default: ;
            endcase
        end
    end

    assign BUSY      = (state != IDLE);
    assign DATAAVAIL = (QCNT != 5'd0) || (state != IDLE);

`ifdef SCA_RD_SCHED_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            EVT_CNT  <= '0;
            DROP_CNT <= '0;
        end else begin
            if (state == DONE) EVT_CNT <= EVT_CNT + 16'd1;
            if (drop && (DROP_CNT != 8'hFF)) DROP_CNT <= DROP_CNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sca_rd_sched.sv
// Scoreboard bench for sca_rd_sched: expected events are queued at L1A time and
// checked by an independent monitor against RADR, CHADR, strobes and release timing.
module tb_sca_rd_sched;

    localparam int NSAMP      = 8;
    localparam int DEPTH      = 4;
    localparam int SETTLE_CYC = 2;
    localparam int CONV_CYC   = 6;
    localparam int EVT_LAT    = NSAMP * (1 + SETTLE_CYC + 1 + CONV_CYC + 16 + 1) + 1;
    // Each queued event also spends one IDLE cycle being dequeued.
    localparam int EVT_PERIOD = EVT_LAT + 1;

    logic        CLK = 1'b0;
    logic        RST, L1A_MATCH, OUT_RDY;
    logic [6:0]  L1A_BLK;
    logic [6:0]  RADR, FREE_BLK;
    logic [3:0]  CHADR;
    logic        ADC_CONV, WORD_STB, FIRST_WORD, LASTWORD, FREE_STB, DATAAVAIL, BUSY, OVFL;
    logic [4:0]  QCNT;
`ifdef SCA_RD_SCHED_CNT_EN
    logic [15:0] EVT_CNT;
    logic [7:0]  DROP_CNT;
`endif
    logic [30:0] all_outs;

    typedef struct {
        logic [6:0] blk;
        int         exp_cyc;
    } free_t;
    typedef struct {
        logic [3:0] ch;
        logic       first;
    } word_t;

    free_t      free_q[$];
    logic [6:0] radr_q[$];
    word_t      word_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_evt  = 0;
    int exp_drop = 0;
    bit ovfl_exp = 1'b0;

    sca_rd_sched #(.NSAMP(NSAMP), .DEPTH(DEPTH), .SETTLE_CYC(SETTLE_CYC), .CONV_CYC(CONV_CYC)) dut (
        .CLK(CLK), .RST(RST), .L1A_MATCH(L1A_MATCH), .L1A_BLK(L1A_BLK), .OUT_RDY(OUT_RDY),
        .RADR(RADR), .CHADR(CHADR), .ADC_CONV(ADC_CONV), .WORD_STB(WORD_STB),
        .FIRST_WORD(FIRST_WORD), .LASTWORD(LASTWORD), .FREE_STB(FREE_STB), .FREE_BLK(FREE_BLK),
        .DATAAVAIL(DATAAVAIL), .BUSY(BUSY), .QCNT(QCNT), .OVFL(OVFL)
`ifdef SCA_RD_SCHED_CNT_EN
        , .EVT_CNT(EVT_CNT), .DROP_CNT(DROP_CNT)
`endif
    );

    assign all_outs = {RADR, CHADR, ADC_CONV, WORD_STB, FIRST_WORD, LASTWORD, FREE_STB,
                       FREE_BLK, DATAAVAIL, BUSY, QCNT, OVFL};

    always #12 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event/timeout, expected none (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_rdy(input bit rnd);
        OUT_RDY = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    // Reference model of one event: NSAMP read addresses wrapping at 96, 16 words per sample.
    task automatic push_event(input logic [6:0] blk, input int exp_cyc);
        free_t f;
        word_t w;
        f.blk     = blk;
        f.exp_cyc = exp_cyc;
        free_q.push_back(f);
        for (int s = 0; s < NSAMP; s++) begin
            radr_q.push_back(7'((int'(blk) + s) % 96));
            for (int c = 0; c < 16; c++) begin
                w.ch    = 4'(c);
                w.first = (s == 0) && (c == 0);
                word_q.push_back(w);
            end
        end
        exp_evt++;
    endtask

    // Burst issued from idle: the first pulse starts an event, the next DEPTH fill the queue,
    // any further pulses are dropped (all pulses land well inside the first event).
    task automatic issue_burst(input int n, input int maxgap, input bit rnd, input int first_blk,
                               input int extra);
        int         t0;
        int         acc;
        int         gap;
        logic [6:0] blk;
        acc = 0;
        t0  = cyc;
        for (int i = 0; i < n; i++) begin
            blk       = (i == 0 && first_blk >= 0) ? 7'(first_blk) : 7'($urandom_range(0, 95));
            L1A_MATCH = 1'b1;
            L1A_BLK   = blk;
            drive_rdy(rnd);
            if (acc < DEPTH + 1) begin
                push_event(blk, rnd ? -1 : t0 + (acc + 1) * EVT_PERIOD + extra);
                acc++;
            end else begin
                exp_drop++;
                ovfl_exp = 1'b1;
            end
            tick();
            L1A_MATCH = 1'b0;
            gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            for (int g = 0; g < gap; g++) begin
                drive_rdy(rnd);
                tick();
            end
        end
        drive_rdy(rnd);
        tick();
        check("qcnt_after_burst", QCNT, acc - 1);
        check("ovfl_after_burst", OVFL, ovfl_exp);
    endtask

    task automatic wait_idle(input bit rnd);
        int k;
        for (k = 0; k < 8000; k++) begin
            drive_rdy(rnd);
            tick();
            if (!BUSY && QCNT == 5'd0) break;
        end
        if (k == 8000) flag_fail("idle_timeout");
        OUT_RDY = 1'b1;
        tick();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe.
    initial begin
        int    conv_seen, word_seen, first_seen;
        word_t w;
        free_t f;
        conv_seen  = 0;
        word_seen  = 0;
        first_seen = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                free_q.delete();
                radr_q.delete();
                word_q.delete();
                conv_seen  = 0;
                word_seen  = 0;
                first_seen = 0;
            end else begin
                if (ADC_CONV) begin
                    conv_seen++;
                    if (radr_q.size() == 0) flag_fail("unexpected_adc_conv");
                    else check("radr_at_conv", RADR, radr_q.pop_front());
                end
                if (FIRST_WORD) check("first_word_qualified", WORD_STB, 1);
                if (WORD_STB) begin
                    word_seen++;
                    if (FIRST_WORD) first_seen++;
                    check("word_stb_needs_rdy", OUT_RDY, 1);
                    if (word_q.size() == 0) flag_fail("unexpected_word_stb");
                    else begin
                        w = word_q.pop_front();
                        check("chadr_at_word", CHADR, w.ch);
                        check("first_word_flag", FIRST_WORD, w.first);
                    end
                end
                if (FREE_STB) begin
                    check("lastword_with_free", LASTWORD, 1);
                    if (free_q.size() == 0) flag_fail("unexpected_free_stb");
                    else begin
                        f = free_q.pop_front();
                        check("free_blk_order", FREE_BLK, f.blk);
                        if (f.exp_cyc >= 0) check("free_cycle", cyc, f.exp_cyc);
                        check("conv_per_event", conv_seen, NSAMP);
                        check("words_per_event", word_seen, NSAMP * 16);
                        check("first_per_event", first_seen, 1);
                    end
                    conv_seen  = 0;
                    word_seen  = 0;
                    first_seen = 0;
                end else if (LASTWORD) begin
                    flag_fail("lastword_without_free");
                end
            end
        end
    end

    initial begin
        int d;
        int k;
        logic [6:0] blk;
        RST       = 1'b1;
        L1A_MATCH = 1'b0;
        L1A_BLK   = '0;
        OUT_RDY   = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_outputs", {1'b0, all_outs}, 0);
        tick();
        RST = 1'b0;
        tick();

        // Single events: plain base, then one that wraps past cell 95.
        issue_burst(1, 0, 1'b0, 10, 0);
        wait_idle(1'b0);
        issue_burst(1, 0, 1'b0, 92, 0);
        wait_idle(1'b0);

        // Six back-to-back pulses: five accepted, one dropped.
        issue_burst(6, 0, 1'b0, -1, 0);
        wait_idle(1'b0);
`ifdef SCA_RD_SCHED_CNT_EN
        check("drop_cnt_after_overflow", DROP_CNT, exp_drop);
        check("evt_cnt_after_overflow", EVT_CNT, exp_evt);
`endif

        // Ten-cycle downstream stall at channel 7.
        issue_burst(1, 0, 1'b0, 40, 10);
        for (k = 0; k < 200; k++) begin
            tick();
            if (CHADR == 4'd7) break;
        end
        if (k == 200) flag_fail("stall_chadr7_timeout");
        OUT_RDY = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("stall_chadr_hold", CHADR, 7);
            check("stall_no_word", WORD_STB, 0);
            tick();
        end
        OUT_RDY = 1'b1;
        wait_idle(1'b0);

        // Reset mid-SHIFT with two events queued.
        issue_burst(3, 0, 1'b0, -1, 0);
        for (k = 0; k < 200; k++) begin
            tick();
            if (WORD_STB) break;
        end
        if (k == 200) flag_fail("shift_timeout");
        RST = 1'b1;
        #1;
        check("abort_outputs", {1'b0, all_outs}, 0);
        ovfl_exp = 1'b0;
        exp_evt  = 0;
        exp_drop = 0;
        tick();
        tick();
        RST = 1'b0;
        repeat (5) tick();
        check("idle_after_abort", {BUSY, DATAAVAIL}, 0);
        issue_burst(1, 0, 1'b0, -1, 0);
        wait_idle(1'b0);

        // Enqueue on a full queue in the dequeue cycle is accepted without overflow.
        issue_burst(5, 0, 1'b0, -1, 0);
        for (k = 0; k < 400; k++) begin
            tick();
            if (FREE_STB) break;
        end
        if (k == 400) flag_fail("first_free_timeout");
        d = cyc;
        tick();
        blk       = 7'($urandom_range(0, 95));
        L1A_MATCH = 1'b1;
        L1A_BLK   = blk;
        push_event(blk, d + 5 * EVT_PERIOD);
        tick();
        L1A_MATCH = 1'b0;
        check("qcnt_full_enq_deq", QCNT, DEPTH);
        check("ovfl_full_enq_deq", OVFL, 0);
        wait_idle(1'b0);

        // Randomized bursts with random gaps and random downstream stalls.
        for (int it = 0; it < 10; it++) begin
            wait_idle(1'b1);
            issue_burst(int'($urandom_range(1, 7)), 3, 1'b1, -1, 0);
        end
        wait_idle(1'b1);
        wait_idle(1'b0);

        check("free_q_drained", free_q.size(), 0);
        check("word_q_drained", word_q.size(), 0);
        check("final_ovfl", OVFL, ovfl_exp);
`ifdef SCA_RD_SCHED_CNT_EN
        check("final_evt_cnt", EVT_CNT, exp_evt);
        check("final_drop_cnt", DROP_CNT, exp_drop);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
